// File: rtl/mos6502_operand_fetch.sv
// 6502 operand fetch stage: accepts a decoded opcode, fetches 0-2 operand bytes, holds for execute.
// Optional USE_POWER_PINS adds vdd/vss; optional MOS6502_MODE_CHECK_EN adds sticky mode_err_o.
module mos6502_operand_fetch (
`ifdef USE_POWER_PINS
  inout  wire         vdd,
  inout  wire         vss,
`endif
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [65:0] decoded_instruction_i,
  input  logic        opcode_valid_i,
  output logic        opcode_ready_o,
  output logic        fetch_req_o,
  input  logic [7:0]  mem_data_i,
  input  logic        mem_valid_i,
  output logic        pc_inc_o,
  output logic [65:0] decoded_instruction_o,
  output logic [7:0]  operand_lo_o,
  output logic [7:0]  operand_hi_o,
  output logic [1:0]  operand_count_o,
  output logic        operand_valid_o,
  input  logic        operand_ready_i,
  output logic        busy_o
`ifdef MOS6502_MODE_CHECK_EN
  ,
  output logic        mode_err_o
`endif
);

  typedef enum logic [1:0] {StIdle, StFetchLo, StFetchHi, StHold} state_e;

  // Modes needing two operand bytes: absX, absY, abs, ind.
  localparam logic [65:0] TwoByteMask = (66'd1 << 57) | (66'd1 << 58) | (66'd1 << 59) |
                                        (66'd1 << 62);

  state_e      state_q, state_d;
  logic [65:0] instr_q, instr_d;
  logic [7:0]  lo_q, lo_d, hi_q, hi_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        two_q, two_d;
  logic [1:0]  req_cnt;
  logic        accept, fetching, take;

  // Scan high to low so the lowest-index set mode bit decides.
  always_comb begin
    req_cnt = 2'd0;
    for (int i = 65; i >= 56; i--) begin
      if (decoded_instruction_i[i]) req_cnt = TwoByteMask[i] ? 2'd2 : 2'd1;
    end
  end

  // Reset gates every combinational output so handshakes cannot fire in the reset cycle.
  always_comb begin
    fetching        = (state_q == StFetchLo) || (state_q == StFetchHi);
    opcode_ready_o  = !rst_i && ((state_q == StIdle) || ((state_q == StHold) && operand_ready_i));
    accept          = opcode_ready_o && opcode_valid_i;
    take            = !rst_i && fetching && mem_valid_i;
    fetch_req_o     = !rst_i && fetching;
    pc_inc_o        = take;
    operand_valid_o = !rst_i && (state_q == StHold);
    busy_o          = !rst_i && (state_q != StIdle);
  end

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    cnt_d   = cnt_q;
    two_d   = two_q;
    unique case (state_q)
      StIdle: ;
      StFetchLo: begin
        if (take) begin
          lo_d    = mem_data_i;
          cnt_d   = cnt_q + 2'd1;
          state_d = two_q ? StFetchHi : StHold;
        end
      end
      StFetchHi: begin
        if (take) begin
          hi_d    = mem_data_i;
          cnt_d   = cnt_q + 2'd1;
          state_d = StHold;
        end
      end
      StHold: begin
        if (operand_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (accept) begin
      instr_d = decoded_instruction_i;
      lo_d    = 8'h00;
      hi_d    = 8'h00;
      cnt_d   = 2'd0;
      two_d   = (req_cnt == 2'd2);
      state_d = (req_cnt == 2'd0) ? StHold : StFetchLo;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      instr_q <= '0;
      lo_q    <= 8'h00;
      hi_q    <= 8'h00;
      cnt_q   <= 2'd0;
      two_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      cnt_q   <= cnt_d;
      two_q   <= two_d;
    end
  end

  assign decoded_instruction_o = instr_q;
  assign operand_lo_o          = lo_q;
  assign operand_hi_o          = hi_q;
  assign operand_count_o       = cnt_q;

`ifdef MOS6502_MODE_CHECK_EN
  logic mode_err_q, mode_err_d;
  logic multi_mode;

  always_comb begin
    multi_mode = $countones({decoded_instruction_i[65:56], decoded_instruction_i[3]}) > 1;
    mode_err_d = mode_err_q || (accept && multi_mode);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) mode_err_q <= 1'b0;
    else       mode_err_q <= mode_err_d;
  end

  assign mode_err_o = mode_err_q;
`endif

endmodule

// File: tb/tb_mos6502_operand_fetch.sv
// Self-checking bench for mos6502_operand_fetch: directed scenarios plus randomized opcodes
// checked against a transaction-level model of operand length, bytes and latency.
module tb_mos6502_operand_fetch;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [65:0] di;
  logic        opcode_valid, opcode_ready, fetch_req, mem_valid, pc_inc;
  logic [7:0]  mem_data, lo, hi;
  logic [65:0] dout;
  logic [1:0]  cnt;
  logic        op_valid, op_ready, busy;
`ifdef MOS6502_MODE_CHECK_EN
  logic        mode_err;
`endif
`ifdef USE_POWER_PINS
  wire         vdd, vss;
`endif

  int   checks = 0;
  int   errors = 0;
  logic exp_err = 1'b0;
  logic in_hold = 1'b0;

  always #5 clk = ~clk;

  mos6502_operand_fetch dut (
`ifdef USE_POWER_PINS
    .vdd                   (vdd),
    .vss                   (vss),
`endif
    .clk_i                 (clk),
    .rst_i                 (rst_i),
    .decoded_instruction_i (di),
    .opcode_valid_i        (opcode_valid),
    .opcode_ready_o        (opcode_ready),
    .fetch_req_o           (fetch_req),
    .mem_data_i            (mem_data),
    .mem_valid_i           (mem_valid),
    .pc_inc_o              (pc_inc),
    .decoded_instruction_o (dout),
    .operand_lo_o          (lo),
    .operand_hi_o          (hi),
    .operand_count_o       (cnt),
    .operand_valid_o       (op_valid),
    .operand_ready_i       (op_ready),
    .busy_o                (busy)
`ifdef MOS6502_MODE_CHECK_EN
    ,
    .mode_err_o            (mode_err)
`endif
  );

  task automatic chk(input string tag, input logic [65:0] got, input logic [65:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $display("FAIL %s: observed %h expected %h", tag, got, exp);
      $error("check %s", tag);
    end
  endtask

  // Operand length of each mode bit 56..65 (Xind absX absY abs hash indY ind rel zpgX zpg).
  function automatic int ref_count(input logic [65:0] d);
    int len [10];
    len = '{1, 2, 2, 2, 1, 1, 2, 1, 1, 1};
    for (int k = 0; k < 10; k++) if (d[56 + k]) return len[k];
    return 0;
  endfunction

  function automatic logic [65:0] rand_bits();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[65:0];
  endfunction

  function automatic logic [65:0] one_hot(input int b);
    return 66'd1 << b;
  endfunction

  function automatic logic [65:0] rand_instr();
    logic [65:0] d;
    int pick;
    d = rand_bits();
    d[65:56] = '0;
    d[3] = 1'b0;
    pick = $urandom_range(0, 13);
    if (pick < 10) d[56 + pick] = 1'b1;
    else if (pick == 10) d[3] = 1'b1;
    else if (pick == 12) begin
      d[56 + $urandom_range(0, 9)] = 1'b1;
      d[56 + $urandom_range(0, 9)] = 1'b1;
    end
    return d;
  endfunction

  // Starts at a negedge in IDLE or HOLD; ends at a negedge in HOLD.
  task automatic do_op(input logic [65:0] d, input logic [7:0] b0, input logic [7:0] b1,
                       input int stalls);
    int need, cyc, reqs, taken, st, exp_lat;
    logic [7:0] lo_e, hi_e;
    need    = ref_count(d);
    lo_e    = (need >= 1) ? b0 : 8'h00;
    hi_e    = (need == 2) ? b1 : 8'h00;
    exp_lat = 1 + need + ((need > 0) ? stalls : 0);
    if ($countones({d[3], d[65:56]}) > 1) exp_err = 1'b1;
    opcode_valid = 1'b1;
    di           = d;
    op_ready     = in_hold;
    mem_valid    = 1'($urandom_range(0, 1));
    mem_data     = 8'($urandom());
    #1 chk("accept_ready", opcode_ready, 1);
    @(negedge clk);
    opcode_valid = 1'b0;
    op_ready     = 1'b0;
    di           = rand_bits();
    chk("decoded_next", dout, d);
    chk("busy_after_accept", busy, 1);
    cyc = 1; reqs = 0; taken = 0; st = stalls;
    while (!op_valid && cyc <= 60) begin
      mem_valid = (st == 0);
      mem_data  = (taken == 0) ? b0 : b1;
      #1;
      if (fetch_req) reqs++;
      if (pc_inc) taken++;
      if (fetch_req && st > 0) st--;
      @(negedge clk);
      cyc++;
    end
    mem_valid = 1'b0;
    chk("latency", cyc, exp_lat);
    chk("fetch_req_cycles", reqs, need + ((need > 0) ? stalls : 0));
    chk("pc_inc_pulses", taken, need);
    chk("operand_lo", lo, lo_e);
    chk("operand_hi", hi, hi_e);
    chk("operand_count", cnt, need);
    // HOLD must ignore memory and a new opcode while execute is not ready.
    mem_valid    = 1'b1;
    mem_data     = ~lo_e;
    opcode_valid = 1'b1;
    di           = rand_bits();
    #1;
    chk("hold_no_fetch", fetch_req, 0);
    chk("hold_no_inc", pc_inc, 0);
    chk("hold_not_ready", opcode_ready, 0);
    @(negedge clk);
    opcode_valid = 1'b0;
    mem_valid    = 1'b0;
    chk("hold_valid", op_valid, 1);
    chk("hold_lo_stable", lo, lo_e);
    chk("hold_hi_stable", hi, hi_e);
    chk("hold_decoded_stable", dout, d);
`ifdef MOS6502_MODE_CHECK_EN
    chk("mode_err", mode_err, exp_err);
`endif
    in_hold = 1'b1;
  endtask

  task automatic release_hold();
    op_ready = 1'b1;
    #1 chk("release_ready", opcode_ready, 1);
    @(negedge clk);
    op_ready = 1'b0;
    chk("idle_busy", busy, 0);
    chk("idle_valid", op_valid, 0);
    chk("idle_ready", opcode_ready, 1);
    in_hold = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, opcode_ready, 0);
    chk({tag, "_fetch"}, fetch_req, 0);
    chk({tag, "_inc"}, pc_inc, 0);
    chk({tag, "_decoded"}, dout, 0);
    chk({tag, "_lo"}, lo, 0);
    chk({tag, "_hi"}, hi, 0);
    chk({tag, "_count"}, cnt, 0);
    chk({tag, "_valid"}, op_valid, 0);
    chk({tag, "_busy"}, busy, 0);
`ifdef MOS6502_MODE_CHECK_EN
    chk({tag, "_mode_err"}, mode_err, 0);
`endif
  endtask

  initial begin
    rst_i = 1'b1; di = '0; opcode_valid = 1'b0; mem_data = 8'h00; mem_valid = 1'b0;
    op_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_i = 1'b0;
    #1 chk("ready_after_reset", opcode_ready, 1);
    @(negedge clk);

    do_op(one_hot(59), 8'h34, 8'h12, 0);   // abs, no stalls
    release_hold();
    do_op(one_hot(60), 8'hA5, 8'h77, 4);   // hash, four stall cycles
    release_hold();
    do_op('0, 8'h11, 8'h22, 0);            // implied
    do_op(one_hot(3), 8'h33, 8'h44, 2);    // A, back-to-back from HOLD
    release_hold();
    do_op(one_hot(65), 8'h5A, 8'h00, 1);   // zpg
    do_op(one_hot(62), 8'hC3, 8'h3C, 0);   // ind, back-to-back
    release_hold();

    // Reset in FETCH_HI with every handshake asserted.
    opcode_valid = 1'b1; di = one_hot(59);
    @(negedge clk);
    opcode_valid = 1'b0; mem_valid = 1'b1; mem_data = 8'h55;
    @(negedge clk);
    mem_valid = 1'b0;
    #1 chk("in_fetch_hi", fetch_req, 1);
    rst_i = 1'b1; mem_valid = 1'b1; opcode_valid = 1'b1; op_ready = 1'b1; di = one_hot(57);
    #1;
    chk("rst_cycle_inc", pc_inc, 0);
    chk("rst_cycle_fetch", fetch_req, 0);
    chk("rst_cycle_ready", opcode_ready, 0);
    @(negedge clk);
    chk_all_zero("mid_reset");
    rst_i = 1'b0; mem_valid = 1'b0; opcode_valid = 1'b0; op_ready = 1'b0;
    exp_err = 1'b0; in_hold = 1'b0;
    #1 chk("ready_after_mid_reset", opcode_ready, 1);
    @(negedge clk);
    do_op(one_hot(57), 8'h9E, 8'h80, 1);
    release_hold();

    for (int n = 0; n < 40; n++) begin
      do_op(rand_instr(), 8'($urandom()), 8'($urandom()), $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) release_hold();
    end
    if (in_hold) release_hold();

`ifdef MOS6502_MODE_CHECK_EN
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0; exp_err = 1'b0;
    @(negedge clk);
    do_op(one_hot(59) | one_hot(60), 8'h01, 8'h02, 0);
    chk("multi_mode_count", cnt, 2);
    chk("multi_mode_err", mode_err, 1);
    release_hold();
    do_op(one_hot(64), 8'h03, 8'h04, 0);
    chk("mode_err_sticky", mode_err, 1);
    release_hold();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mos6502_operand_fetch.md
MOS6502_OPERAND_FETCH -- requirements
Module: mos6502_operand_fetch

Interface
REQ-001 Parameter: none; all widths SHALL be fixed.
REQ-002 clk_i  input  1  single clock; every flop SHALL be rising-edge.
REQ-003 rst_i  input  1  synchronous, active-high reset.
REQ-004 vdd, vss  inout  1  present only when USE_POWER_PINS is defined.
REQ-005 decoded_instruction_i  input  66  decoder output. Addressing-mode bits: 3 = A, 56 = Xind, 57 = absX, 58 = absY, 59 = abs, 60 = hash, 61 = indY, 62 = ind, 63 = rel, 64 = zpgX, 65 = zpg.
REQ-006 opcode_valid_i / opcode_ready_o  in/out  1  opcode handshake; accept when both are high.
REQ-007 fetch_req_o  output  1  request for the next operand byte at PC.
REQ-008 mem_data_i  input  8  memory byte.
REQ-009 mem_valid_i  input  1  byte is taken when fetch_req_o and mem_valid_i are both high.
REQ-010 pc_inc_o  output  1  one-cycle pulse per byte taken.
REQ-011 decoded_instruction_o  output  66  registered copy of the accepted decode.
REQ-012 operand_lo_o, operand_hi_o  output  8 each  operand bytes.
REQ-013 operand_count_o  output  2  number of operand bytes fetched (0, 1 or 2).
REQ-014 operand_valid_o / operand_ready_i  out/in  1  handoff to execute; transfer when both are high.
REQ-015 busy_o  output  1  high in any state other than IDLE.
REQ-016 mode_err_o  output  1  sticky flag; present only with the macro in REQ-036.

Function
REQ-017 Operand count SHALL be:
- 2 when abs, absX, absY or ind is set.
- 1 when hash, zpg, zpgX, Xind, indY or rel is set.
- 0 otherwise, including A and implied.
REQ-018 States: IDLE, FETCH_LO, FETCH_HI, HOLD.
REQ-019 opcode_ready_o SHALL be high in IDLE, and also in HOLD when operand_ready_i is high.
REQ-020 On accept, decoded_instruction_i SHALL be registered and operand_lo_o/operand_hi_o cleared to 0x00. Next state is FETCH_LO if count is at least 1, else HOLD.
REQ-021 fetch_req_o SHALL be high exactly in FETCH_LO and FETCH_HI.
REQ-022 In FETCH_LO, a taken byte SHALL load operand_lo_o. Next state is FETCH_HI if count is 2, else HOLD.
REQ-023 In FETCH_HI, a taken byte SHALL load operand_hi_o, then go to HOLD.
REQ-024 While mem_valid_i is low in FETCH_LO/FETCH_HI, the block SHALL stall with fetch_req_o held high.
REQ-025 pc_inc_o SHALL pulse in the same cycle a byte is taken.
REQ-026 operand_valid_o SHALL be high exactly in HOLD.
- Outputs SHALL stay stable until transfer.
- On transfer without a new opcode, go to IDLE.
REQ-027 If transfer and opcode accept happen in the same cycle, new data SHALL load per REQ-020 (back-to-back, no IDLE bubble).
REQ-028 Latency from opcode accept to operand_valid_o, with mem_valid_i held high: 1 cycle (0 operands), 2 cycles (1 operand), 3 cycles (2 operands).
REQ-029 mem_valid_i SHALL be ignored outside FETCH states. opcode_valid_i SHALL be ignored while opcode_ready_o is low.
REQ-030 If several mode bits are set, the lowest-index set bit of 56..65 SHALL select the count.

Reset
REQ-031 rst_i SHALL force IDLE from any state, including mid-fetch.
REQ-032 During reset, all outputs SHALL be 0, except opcode_ready_o, which SHALL read 1 in the cycle after reset releases.
REQ-033 Reset SHALL take priority over every simultaneous handshake.
REQ-034 Partially fetched operands SHALL be discarded on reset; no pc_inc_o pulse SHALL occur in the reset cycle.

Configuration
REQ-035 Macro name: MOS6502_MODE_CHECK_EN.
REQ-036 Defined:
- mode_err_o SHALL exist.
- It SHALL set on any accepted opcode with more than one of bits 3, 56..65 set.
- It SHALL stay set until rst_i; fetch behaviour is unchanged.
REQ-037 Undefined: the port and its logic SHALL be absent.

Verification
REQ-038 Accept abs only (bit 59), then memory supplies 0x34, 0x12 with mem_valid_i high -> HOLD in 3 cycles; operand_lo_o = 0x34, operand_hi_o = 0x12, count = 2, two pc_inc_o pulses.
REQ-039 Accept hash only (bit 60), byte 0xA5, mem_valid_i low for 4 cycles first -> fetch_req_o high for 5 cycles; operand_lo_o = 0xA5, operand_hi_o = 0x00, count = 1.
REQ-040 Accept implied (no mode bits), then A only (bit 3) -> each gives operand_valid_o one cycle after accept, count = 0, no fetch_req_o.
REQ-041 HOLD with operand_ready_i high and opcode_valid_i high in the same cycle -> new opcode accepted, no IDLE cycle, decoded_instruction_o updates the next cycle.
REQ-042 rst_i asserted in FETCH_HI -> next cycle IDLE, all outputs 0, then opcode_ready_o = 1; a later opcode fetches normally.
REQ-043 With MOS6502_MODE_CHECK_EN: accept bits 59 and 60 both set -> mode_err_o = 1, count = 2, and mode_err_o stays 1 after the next clean opcode.
